// File: rtl/demux1an_rr_param.sv
// Round-robin 1-to-LANES word demultiplexer: collects words into per-lane holding
// registers and emits full groups, or idle-flushed partial groups, with per-lane valids.
module demux1an_rr_param #(
    parameter int WIDTH         = 8,
    parameter int LANES         = 4,
    parameter int FLUSH_PARTIAL = 1,
    parameter int IDLE_CYCLES   = 2
) (
    input  logic                       clk_4f,
    input  logic                       reset_L,
    input  logic                       sync_clear,
    input  logic                       valid_in,
    input  logic [WIDTH-1:0]           data_in,
    output logic [LANES*WIDTH-1:0]     data_out,
    output logic [LANES-1:0]           valid_out,
    output logic                       group_strobe,
    output logic                       partial,
    output logic [$clog2(LANES)-1:0]   lane_ptr
);

    localparam int PW = $clog2(LANES);
    localparam int IW = 4;
    localparam logic [PW-1:0] LAST_LANE = PW'(LANES - 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_CYCLES);
    localparam logic [IW-1:0] IDLE_PRE  = IW'(IDLE_CYCLES - 1);

    // valid_in qualifies data_in with no backpressure: every valid word is taken on the
    // edge it is presented, unless sync_clear is high in that cycle.
    logic [PW-1:0]                  ptr_q, ptr_d;
    logic [LANES-1:0]               fill_q, fill_d;
    logic [IW-1:0]                  idle_q, idle_d;
    logic [LANES-2:0][WIDTH-1:0]    shadow_q, shadow_d;
    logic [LANES*WIDTH-1:0]         data_out_q, data_out_d;
    logic [LANES-1:0]               valid_out_q, valid_out_d;
    logic                           strobe_q, strobe_d;
    logic                           partial_q, partial_d;

    logic                           full_emit;
    logic                           flush_emit;
    logic [IW-1:0]                  idle_next;

    assign full_emit  = valid_in && !sync_clear && (ptr_q == LAST_LANE);
    assign idle_next  = (idle_q == IDLE_MAX) ? idle_q : idle_q + 4'd1;
    // Flush only on the edge where the idle count first reaches its limit, so one per idle period.
    assign flush_emit = (FLUSH_PARTIAL != 0) && !sync_clear && !valid_in &&
                        (idle_q == IDLE_PRE) && (|fill_q);

    always_comb begin
        ptr_d       = ptr_q;
        fill_d      = fill_q;
        idle_d      = idle_q;
        shadow_d    = shadow_q;
        data_out_d  = data_out_q;
        valid_out_d = '0;
        strobe_d    = 1'b0;
        partial_d   = 1'b0;

        if (sync_clear) begin
            ptr_d  = '0;
            fill_d = '0;
            idle_d = '0;
        end else if (valid_in) begin
            idle_d = '0;
            if (full_emit) begin
                data_out_d  = {data_in, shadow_q};
                valid_out_d = '1;
                strobe_d    = 1'b1;
                ptr_d       = '0;
                fill_d      = '0;
            end else begin
                for (int k = 0; k < LANES - 1; k++) begin
                    if (ptr_q == PW'(k)) begin
                        shadow_d[k] = data_in;
                    end
                end
                fill_d[ptr_q] = 1'b1;
                ptr_d         = ptr_q + 1'b1;
            end
        end else begin
            idle_d = idle_next;
            if (flush_emit) begin
                data_out_d = '0;
                for (int k = 0; k < LANES - 1; k++) begin
                    if (fill_q[k]) begin
                        data_out_d[k*WIDTH +: WIDTH] = shadow_q[k];
                    end
                end
                valid_out_d = fill_q;
                strobe_d    = 1'b1;
                partial_d   = 1'b1;
                ptr_d       = '0;
                fill_d      = '0;
            end
        end
    end

    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            ptr_q       <= '0;
            fill_q      <= '0;
            idle_q      <= '0;
            shadow_q    <= '0;
            data_out_q  <= '0;
            valid_out_q <= '0;
            strobe_q    <= 1'b0;
            partial_q   <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            fill_q      <= fill_d;
            idle_q      <= idle_d;
            shadow_q    <= shadow_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            strobe_q    <= strobe_d;
            partial_q   <= partial_d;
        end
    end

    assign data_out     = data_out_q;
    assign valid_out    = valid_out_q;
    assign group_strobe = strobe_q;
    assign partial      = partial_q;
    assign lane_ptr     = ptr_q;

endmodule

// File: tb/tb_demux1an_rr_param.sv
// Bench for demux1an_rr_param: three parameterisations share one stimulus stream and
// are checked every cycle against a queue-of-words reference model.
module tb_demux1an_rr_param;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sync_clear = 1'b0;
    logic        valid_in = 1'b0;
    logic [15:0] data_in = '0;

    always #5 clk = ~clk;

    logic [31:0]  d0_data, d1_data;
    logic [127:0] d2_data;
    logic [3:0]   d0_valid, d1_valid;
    logic [7:0]   d2_valid;
    logic         d0_gs, d1_gs, d2_gs, d0_pt, d1_pt, d2_pt;
    logic [1:0]   d0_ptr, d1_ptr;
    logic [2:0]   d2_ptr;

    demux1an_rr_param #(.WIDTH(8), .LANES(4), .FLUSH_PARTIAL(1), .IDLE_CYCLES(2)) u0 (
        .clk_4f(clk), .reset_L(rst_n), .sync_clear(sync_clear), .valid_in(valid_in),
        .data_in(data_in[7:0]), .data_out(d0_data), .valid_out(d0_valid),
        .group_strobe(d0_gs), .partial(d0_pt), .lane_ptr(d0_ptr));

    demux1an_rr_param #(.WIDTH(8), .LANES(4), .FLUSH_PARTIAL(0), .IDLE_CYCLES(2)) u1 (
        .clk_4f(clk), .reset_L(rst_n), .sync_clear(sync_clear), .valid_in(valid_in),
        .data_in(data_in[7:0]), .data_out(d1_data), .valid_out(d1_valid),
        .group_strobe(d1_gs), .partial(d1_pt), .lane_ptr(d1_ptr));

    demux1an_rr_param #(.WIDTH(16), .LANES(8), .FLUSH_PARTIAL(1), .IDLE_CYCLES(3)) u2 (
        .clk_4f(clk), .reset_L(rst_n), .sync_clear(sync_clear), .valid_in(valid_in),
        .data_in(data_in), .data_out(d2_data), .valid_out(d2_valid),
        .group_strobe(d2_gs), .partial(d2_pt), .lane_ptr(d2_ptr));

    logic [127:0] act_data [NI];
    logic [7:0]   act_valid [NI];
    logic [2:0]   act_ptr [NI];
    logic         act_gs [NI];
    logic         act_pt [NI];

    assign act_data[0] = 128'(d0_data);
    assign act_data[1] = 128'(d1_data);
    assign act_data[2] = d2_data;
    assign act_valid[0] = 8'(d0_valid);
    assign act_valid[1] = 8'(d1_valid);
    assign act_valid[2] = d2_valid;
    assign act_ptr[0] = 3'(d0_ptr);
    assign act_ptr[1] = 3'(d1_ptr);
    assign act_ptr[2] = d2_ptr;
    assign act_gs[0] = d0_gs;
    assign act_gs[1] = d1_gs;
    assign act_gs[2] = d2_gs;
    assign act_pt[0] = d0_pt;
    assign act_pt[1] = d1_pt;
    assign act_pt[2] = d2_pt;

    // Reference model: pending words per instance, emitted as a group when full or on idle flush.
    int m_lanes [NI] = '{4, 4, 8};
    int m_width [NI] = '{8, 8, 16};
    int m_fe    [NI] = '{1, 0, 1};
    int m_ic    [NI] = '{2, 2, 3};

    logic [15:0]  pend [NI][8];
    int           pend_n [NI];
    int           idle_n [NI];
    logic [127:0] exp_data [NI];
    logic [7:0]   exp_valid [NI];
    logic         exp_gs [NI];
    logic         exp_pt [NI];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            pend_n[i]    = 0;
            idle_n[i]    = 0;
            exp_data[i]  = '0;
            exp_valid[i] = '0;
            exp_gs[i]    = 1'b0;
            exp_pt[i]    = 1'b0;
        end
    endtask

    task automatic model_emit(input int i, input logic part);
        exp_data[i] = '0;
        for (int k = 0; k < pend_n[i]; k++)
            exp_data[i] = exp_data[i] | (128'(pend[i][k]) << (k * m_width[i]));
        exp_valid[i] = 8'((1 << pend_n[i]) - 1);
        exp_gs[i]    = 1'b1;
        exp_pt[i]    = part;
        pend_n[i]    = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                for (int i = 0; i < NI; i++) begin
                    exp_valid[i] = '0;
                    exp_gs[i]    = 1'b0;
                    exp_pt[i]    = 1'b0;
                    if (sync_clear) begin
                        pend_n[i] = 0;
                        idle_n[i] = 0;
                    end else if (valid_in) begin
                        pend[i][pend_n[i]] = data_in & 16'((32'd1 << m_width[i]) - 1);
                        pend_n[i]++;
                        idle_n[i] = 0;
                        if (pend_n[i] == m_lanes[i]) model_emit(i, 1'b0);
                    end else begin
                        if (idle_n[i] < m_ic[i]) begin
                            idle_n[i]++;
                            if (m_fe[i] != 0 && idle_n[i] == m_ic[i] && pend_n[i] > 0)
                                model_emit(i, 1'b1);
                        end
                    end
                end
            end
        end
    end

    // Compare process: every falling edge, all instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                check($sformatf("u%0d.data_out", i), act_data[i], exp_data[i]);
                check($sformatf("u%0d.valid_out", i), 128'(act_valid[i]), 128'(exp_valid[i]));
                check($sformatf("u%0d.group_strobe", i), 128'(act_gs[i]), 128'(exp_gs[i]));
                check($sformatf("u%0d.partial", i), 128'(act_pt[i]), 128'(exp_pt[i]));
                check($sformatf("u%0d.lane_ptr", i), 128'(act_ptr[i]), 128'(pend_n[i]));
            end
        end
    end

    task automatic send(input logic v, input logic [15:0] d, input logic c);
        valid_in   = v;
        data_in    = d;
        sync_clear = c;
        @(negedge clk);
    endtask

    int idle_burst;
    int r;

    initial begin
        repeat (3) @(negedge clk);
        check("reset.data", 128'(d0_data), 128'h0);
        check("reset.valid", 128'(d0_valid), 128'h0);
        check("reset.ptr", 128'(d0_ptr), 128'h0);
        check("reset.wide_data", d2_data, 128'h0);
        rst_n = 1'b1;

        // Sustained stream
        for (int w = 0; w < 12; w++) begin
            send(1'b1, 16'(w), 1'b0);
            if (w == 3) check("sus.g0", 128'(d0_data), 128'h03020100);
            if (w == 7) begin
                check("sus.g1", 128'(d0_data), 128'h07060504);
                check("sus.wide", d2_data, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
            end
            if (w == 11) begin
                check("sus.g2", 128'(d0_data), 128'h0B0A0908);
                check("sus.strobe", 128'(d0_gs), 128'h1);
            end
        end

        // Asynchronous reset with two lanes filled
        send(1'b1, 16'hB0, 1'b0);
        send(1'b1, 16'hB1, 1'b0);
        check("mid.ptr", 128'(d0_ptr), 128'h2);
        #2 rst_n = 1'b0;
        #1;
        check("rst.data", 128'(d0_data), 128'h0);
        check("rst.ptr", 128'(d0_ptr), 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        send(1'b1, 16'hA0, 1'b0);
        send(1'b1, 16'hA1, 1'b0);
        send(1'b1, 16'hA2, 1'b0);
        send(1'b1, 16'hA3, 1'b0);
        check("rr.data", 128'(d0_data), 128'hA3A2A1A0);
        check("rr.valid", 128'(d0_valid), 128'hF);
        check("rr.partial", 128'(d0_pt), 128'h0);
        send(1'b0, 16'h0, 1'b0);
        check("hold.valid", 128'(d0_valid), 128'h0);
        check("hold.data", 128'(d0_data), 128'hA3A2A1A0);
        send(1'b0, 16'h0, 1'b0);
        send(1'b0, 16'h0, 1'b0);

        // Partial flush
        send(1'b1, 16'h11, 1'b0);
        send(1'b1, 16'h22, 1'b0);
        send(1'b1, 16'h33, 1'b0);
        send(1'b0, 16'h0, 1'b0);
        check("pf.early", 128'(d0_gs), 128'h0);
        send(1'b0, 16'h0, 1'b0);
        check("pf.valid", 128'(d0_valid), 128'h7);
        check("pf.data", 128'(d0_data), 128'h00332211);
        check("pf.partial", 128'(d0_pt), 128'h1);
        check("pf.noflush", 128'(d1_gs), 128'h0);
        repeat (3) send(1'b0, 16'h0, 1'b0);
        check("pf.quiet", 128'(d0_gs), 128'h0);

        // Near-flush: one idle cycle is not enough
        send(1'b1, 16'h11, 1'b0);
        send(1'b0, 16'h0, 1'b0);
        send(1'b1, 16'h22, 1'b0);
        send(1'b1, 16'h33, 1'b0);
        send(1'b1, 16'h44, 1'b0);
        check("nf.data", 128'(d0_data), 128'h44332211);
        check("nf.partial", 128'(d0_pt), 128'h0);

        // Held partial on the no-flush instance
        send(1'b0, 16'h0, 1'b1);
        send(1'b1, 16'h55, 1'b0);
        send(1'b1, 16'h66, 1'b0);
        repeat (20) send(1'b0, 16'h0, 1'b0);
        check("hold.flushed", 128'(d0_data), 128'h00006655);
        check("hold.ptr", 128'(d1_ptr), 128'h2);
        send(1'b1, 16'h77, 1'b0);
        send(1'b1, 16'h88, 1'b0);
        check("hold.data1", 128'(d1_data), 128'h88776655);
        check("hold.valid1", 128'(d1_valid), 128'hF);

        // sync_clear drops the partial group and the same-cycle word
        send(1'b0, 16'h0, 1'b1);
        send(1'b1, 16'h01, 1'b0);
        send(1'b1, 16'h02, 1'b0);
        send(1'b1, 16'hFF, 1'b1);
        check("clr.strobe", 128'(d0_gs), 128'h0);
        check("clr.ptr", 128'(d0_ptr), 128'h0);
        for (int w = 0; w < 8; w++) begin
            send(1'b1, 16'(16'h10 + w), 1'b0);
            if (w == 3) check("clr.data", 128'(d0_data), 128'h13121110);
        end
        check("clr.wide", d2_data, 128'h0017_0016_0015_0014_0013_0012_0011_0010);
        check("clr.wide_valid", 128'(d2_valid), 128'hFF);

        // Randomised stream with idle bursts and occasional clears
        idle_burst = 0;
        for (int c = 0; c < 2000; c++) begin
            if (idle_burst > 0) begin
                idle_burst--;
                send(1'b0, 16'($urandom_range(0, 65535)), 1'b0);
            end else begin
                r = $urandom_range(0, 99);
                if (r < 3)
                    send(1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)), 1'b1);
                else if (r < 75)
                    send(1'b1, 16'($urandom_range(0, 65535)), 1'b0);
                else begin
                    idle_burst = $urandom_range(0, 4);
                    send(1'b0, 16'h0, 1'b0);
                end
            end
        end
        send(1'b0, 16'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
